// File: rtl/cache_traffic_gen.sv
// Multi-channel cache request generator and response sink with per-channel tag/index sweeps.
// Optional response checking is compiled in when CACHE_TGEN_CHECK_EN is defined.
module cache_traffic_gen #(
   parameter int NUM_CH     = 2,
   parameter int OFFSET_W   = 4,
   parameter int IDX_W      = 3,
   parameter int TAG_W      = 3,
   parameter int NUM_IDX    = 3,
   parameter int TAG_SPAN   = 2,
   parameter int TAG_STRIDE = 4,
   parameter int GAP        = 4,
   parameter int RESP_DELAY = 1,
   parameter int NUM_REQ    = 50,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           mode,
   output logic [NUM_CH*76-1:0] cachereq_msg,
   output logic [NUM_CH-1:0]    cachereq_val,
   input  logic [NUM_CH-1:0]    cachereq_rdy,
   input  logic [NUM_CH*44-1:0] cacheresp_msg,
   input  logic [NUM_CH-1:0]    cacheresp_val,
   output logic [NUM_CH-1:0]    cacheresp_rdy,
   output logic [CNT_W-1:0]     cnt_req,
   output logic [CNT_W-1:0]     cnt_resp,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 busy,
   output logic                 done
);

   localparam int              NW       = $clog2(NUM_CH + 1);
   localparam logic [7:0]      GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [3:0]      DLY      = 4'(RESP_DELAY);
   localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(NUM_REQ);

   typedef enum logic [2:0] {S_IDLE, S_GAP, S_REQ, S_WAIT, S_FIN} state_t;

   function automatic logic [NW-1:0] popcnt(input logic [NUM_CH-1:0] v);
      logic [NW-1:0] s;
      s = '0;
      for (int i = 0; i < NUM_CH; i++) s = s + NW'(v[i]);
      return s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [NW-1:0] n);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W + 1)'(n);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   logic              start_go;
   logic              all_fin;
   logic [1:0]        mode_q;
   logic [NUM_CH-1:0] req_hs;
   logic [NUM_CH-1:0] resp_hs;
   logic [NUM_CH-1:0] ch_fin;

   assign start_go = start && !busy;
   assign all_fin  = &ch_fin;
   assign req_hs   = cachereq_val & cachereq_rdy;
   assign resp_hs  = cacheresp_val & cacheresp_rdy;

   // Mode 3 behaves as read, so it is folded into mode 0 when captured.
   always_ff @(posedge clk) begin
      if (reset)         mode_q <= 2'd0;
      else if (start_go) mode_q <= (mode == 2'd3) ? 2'd0 : mode;
   end

`ifdef CACHE_TGEN_CHECK_EN
   logic [NUM_CH-1:0] ch_err;
`else
   logic unused_resp;
   assign unused_resp = ^cacheresp_msg;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [TAG_W-1:0] BASE    = TAG_W'(c * TAG_STRIDE);
      localparam logic [TAG_W-1:0] TAG_END = TAG_W'(c * TAG_STRIDE + TAG_SPAN);

      state_t           state_q, state_d;
      logic [TAG_W-1:0] tag_q, tag_inc;
      logic [IDX_W-1:0] idx_q, idx_inc;
      logic [CNT_W-1:0] seq_q;
      logic [7:0]       gap_q;
      logic [3:0]       dly_q;
      logic             is_wr, hold_addr;
      logic [1:0]       req_type;
      logic [31:0]      addr, wdata;
      logic [75:0]      msg;
      logic             req_val, rsp_rdy;
      logic [75:0]      req_msg;

      assign is_wr     = (mode_q == 2'd1) || ((mode_q == 2'd2) && !seq_q[0]);
      assign hold_addr = (mode_q == 2'd2) && !seq_q[0];
      assign req_type  = {1'b0, is_wr};
      assign addr      = 32'({tag_q, idx_q, {OFFSET_W{1'b0}}, 2'b00});
      assign wdata     = is_wr ? {8'(c), 24'(seq_q)} : 32'd0;
      assign msg       = {req_type, 8'(seq_q), addr, 2'b00, wdata};
      assign tag_inc   = tag_q + 1'b1;
      assign idx_inc   = idx_q + 1'b1;

      always_ff @(posedge clk) begin
         if (reset) state_q <= S_IDLE;
         else       state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            S_IDLE: if (start_go) state_d = (GAP == 0) ? S_REQ : S_GAP;
            S_GAP:  if (gap_q == GAP_LAST) state_d = S_REQ;
            S_REQ:  if (req_hs[c]) state_d = S_WAIT;
            S_WAIT: if (resp_hs[c])
                       state_d = (seq_q == REQ_LAST) ? S_FIN : ((GAP == 0) ? S_REQ : S_GAP);
            S_FIN:  if (all_fin) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      always_comb begin
         req_val = 1'b0;
         rsp_rdy = 1'b0;
         req_msg = '0;
         case (state_q)
            S_REQ: begin
               req_val = 1'b1;
               req_msg = msg;
            end
            S_WAIT:  rsp_rdy = (dly_q == DLY);
            default: ;
         endcase
      end

      assign cachereq_val[c]             = req_val;
      assign cachereq_msg[c*76 +: 76]    = req_msg;
      assign cacheresp_rdy[c]            = rsp_rdy;
      assign ch_fin[c]                   = (state_q == S_FIN);

      // Sweep position advances on every accepted request except the write half of mode 2.
      always_ff @(posedge clk) begin
         if (reset) begin
            tag_q <= BASE;
            idx_q <= '0;
            seq_q <= '0;
            gap_q <= '0;
            dly_q <= '0;
         end else begin
            gap_q <= (state_q == S_GAP) ? gap_q + 8'd1 : 8'd0;
            if (state_q != S_WAIT || !cacheresp_val[c] || resp_hs[c]) dly_q <= '0;
            else if (dly_q != DLY)                                    dly_q <= dly_q + 4'd1;
            if (start_go) begin
               tag_q <= BASE;
               idx_q <= '0;
               seq_q <= '0;
            end else if (req_hs[c]) begin
               seq_q <= seq_q + 1'b1;
               if (!hold_addr) begin
                  if (tag_inc == TAG_END) begin
                     tag_q <= BASE;
                     idx_q <= (idx_inc == IDX_W'(NUM_IDX)) ? '0 : idx_inc;
                  end else begin
                     tag_q <= tag_inc;
                  end
               end
            end
         end
      end

`ifdef CACHE_TGEN_CHECK_EN
      logic [1:0]  out_type;
      logic [7:0]  out_opq;
      logic [31:0] wr_data;
      logic        out_chk_data;
      logic [43:0] rsp;
      logic        unused_len;

      assign rsp        = cacheresp_msg[c*44 +: 44];
      assign unused_len = ^rsp[33:32];

      always_ff @(posedge clk) begin
         if (req_hs[c]) begin
            out_type <= req_type;
            out_opq  <= 8'(seq_q);
            if (is_wr) wr_data <= wdata;
         end
      end

      always_ff @(posedge clk) begin
         if (reset)          out_chk_data <= 1'b0;
         else if (req_hs[c]) out_chk_data <= (mode_q == 2'd2) && !is_wr;
      end

      assign ch_err[c] = resp_hs[c] && ((rsp[41:34] != out_opq) || (rsp[43:42] != out_type) ||
                                        (out_chk_data && (rsp[31:0] != wr_data)));
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt_req  <= '0;
         cnt_resp <= '0;
      end else if (start_go) begin
         busy     <= 1'b1;
         done     <= 1'b0;
         cnt_req  <= '0;
         cnt_resp <= '0;
      end else begin
         if (busy && all_fin) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
         cnt_req  <= sat_add(cnt_req, popcnt(req_hs));
         cnt_resp <= sat_add(cnt_resp, popcnt(resp_hs));
      end
   end

`ifdef CACHE_TGEN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset || start_go) err_cnt <= '0;
      else                   err_cnt <= sat_add(err_cnt, popcnt(ch_err));
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
Synthesizable multi-channel request generator and response sink for exercising the coherent cache ports. It replaces per-port hand-written stimulus FSMs with one parametrised block. Each channel issues a programmable tag/index sweep of read, write or write-then-read requests over the 76-bit valid/ready request interface. It drains 44-bit responses with a configurable ready delay and keeps request, response and error counters.

Parameters:
NUM_CH, 2, number of independent cache ports driven
OFFSET_W, 4, address offset field width (offset held at 0)
IDX_W, 3, index field width
TAG_W, 3, tag field width; 2+OFFSET_W+IDX_W+TAG_W must be <= 32
NUM_IDX, 3, index wraps to 0 on reaching this value (1..2^IDX_W)
TAG_SPAN, 2, tags visited per index before the index advances
TAG_STRIDE, 4, channel c tag base = c*TAG_STRIDE (mod 2^TAG_W)
GAP, 4, idle cycles between response retirement and the next request valid (0..255)
RESP_DELAY, 1, cycles cacheresp_val must be seen high before rdy is raised (0..15)
NUM_REQ, 50, requests per channel per run (1..2^CNT_W-1)
CNT_W, 16, counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a run; ignored while busy
mode  in  2  0=read, 1=write, 2=write-then-read same address, 3=treated as read; sampled on start
cachereq_msg  out  NUM_CH*76  per channel {type[1:0],opaque[7:0],addr[31:0],len[1:0],data[31:0]}; channel c at [c*76+:76]
cachereq_val  out  NUM_CH  request valid
cachereq_rdy  in  NUM_CH  request ready
cacheresp_msg  in  NUM_CH*44  per channel {type[1:0],opaque[7:0],len[1:0],data[31:0]}
cacheresp_val  in  NUM_CH  response valid
cacheresp_rdy  out  NUM_CH  response ready
cnt_req  out  CNT_W  total accepted requests, all channels
cnt_resp  out  CNT_W  total accepted responses
err_cnt  out  CNT_W  response check failures
busy  out  1  run in progress
done  out  1  high from run completion until next start or reset

Behaviour:
- Reset: all outputs 0, and per-channel state IDLE, tag=base, idx=0, seq=0.
- Per-channel FSM: IDLE -> GAP on start; GAP counts GAP cycles (GAP=0 skips it) -> REQ; REQ holds val=1 and a stable msg until val&rdy -> WAIT; WAIT -> GAP on response handshake, or -> FIN if seq==NUM_REQ. FIN holds until all channels reach FIN.
- Each channel has at most one outstanding request.
- Message fields: type 0=read, 1=write; opaque=seq[7:0]; len=0.
- addr = zero-extended {tag,idx,offset(0),2'b00}.
- data = {c[7:0], seq[23:0]} for writes and 0 for reads.
- Address advance after each request handshake, except after the write half in mode 2:
  - tag+1; if tag==base+TAG_SPAN then tag=base and idx+1.
  - If idx reaches NUM_IDX, idx=0.
  - Arithmetic is mod 2^TAG_W / 2^IDX_W.
- Mode 2: even seq is a write, odd seq is a read of the same address. NUM_REQ counts both halves.
- seq increments on each request handshake.
- cacheresp_rdy: high in WAIT once cacheresp_val has been high for RESP_DELAY consecutive cycles. RESP_DELAY=0 means rdy is combinationally high in WAIT. The delay counter clears when val drops or on handshake.
- cacheresp_val outside WAIT is ignored and rdy stays 0.
- Counters: cnt_req/cnt_resp increment by the number of handshakes in the cycle (simultaneous channels sum). They saturate at all-ones and clear on start.
- done: asserted one cycle after the last channel enters FIN. busy deasserts in that same cycle.
- start while busy: no effect. start in the same cycle as reset: reset wins.
- Reset mid-run: val/rdy drop at the next edge and the outstanding transaction is abandoned.

Optional Feature:
CACHE_TGEN_CHECK_EN:
- Defined: each response is checked.
  - Opaque must equal the outstanding opaque.
  - Type must equal the request type.
  - Mode-2 read data must equal the preceding write data.
  - Each failing response increments err_cnt by 1, regardless of how many fields fail.
- Undefined: no checking logic; err_cnt tied 0.

Test Plan:
1. Reset, start, mode=0, NUM_REQ=6, sink returns responses with matching opaque after 3 cycles -> ch0 tags 0,1,0,1,0,1 with idx 0,0,1,1,2,2; ch1 tags 4,5 likewise; cnt_req=cnt_resp=12; done=1.
2. Back-to-back requests with ready held low 5 cycles -> val stays 1 and msg stays bit-stable until rdy; exactly one count per handshake.
3. mode=2, NUM_REQ=4 -> ch0 sequence write addr 0x000, read 0x000, write 0x200, read 0x200; write data 0x00000000 then 0x00000002.
4. With CHECK_EN, the sink returns wrong opaque once and corrupted read data once -> err_cnt=2.
5. RESP_DELAY=3, cacheresp_val rises -> rdy high exactly 3 cycles later; with RESP_DELAY=0, rdy is high in the same cycle.
6. Reset asserted mid-REQ on both channels, then start -> outputs 0 one cycle later; counters and the sweep restart from the base tags.
